// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Parallel-to-serial frame transmitter. Accepts one word per valid/ready
// handshake and sends it LSB-first as: start bit (0), data bits, optional
// parity bit, stop bit (1). Each line bit is held for CLKS_PER_BIT cycles.
//
// Ports:
//   Clk     in   system clock, all logic on posedge
//   Rst     in   synchronous active-high reset
//   Data_in in   word to send, sampled on the handshake cycle only
//   Valid   in   Data_in is valid
//   Ready   out  can accept a word (registered)
//   Tx      out  serial line, idles high (registered)
//   Txbar   out  complement of Tx (registered on the same edge)
//   Busy    out  frame in progress (registered)
//   Done    out  one-cycle pulse in the last cycle of the stop bit
//
// state  | meaning
// IDLE   | line high, Ready=1, waiting for Valid
// START  | start bit (line low)
// DATA   | data bits, LSB of shift register on the line
// PARITY | parity bit (only reachable when PARITY_EN=1)
// STOP   | stop bit (line high), Done in its last cycle

module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Valid,
  output logic                  Ready,
  output logic                  Tx,
  output logic                  Txbar,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cyc_cnt, cyc_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  par, par_nxt;
  logic                  bit_end;
  logic                  tx_nxt, ready_nxt, busy_nxt, done_nxt;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par;
    bit_end   = (cyc_cnt == CYC_LAST);

    case (state)
      IDLE: begin
        if (Valid) begin
          state_nxt = START;
          cyc_nxt   = '0;
          bit_nxt   = '0;
          shreg_nxt = Data_in;
          // parity is fixed at accept time so later shifts cannot disturb it
          par_nxt   = (^Data_in) ^ PARITY_ODD;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cyc_nxt   = '0;
          bit_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cyc_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            shreg_nxt = shreg >> 1;
          end
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cyc_nxt   = '0;
        bit_nxt   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
    ready_nxt = (state_nxt == IDLE);
    busy_nxt  = ~ready_nxt;
    done_nxt  = (state_nxt == STOP) && (cyc_nxt == CYC_LAST);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      Tx      <= 1'b1;
      Txbar   <= 1'b0;
      Ready   <= 1'b1;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      Tx      <= tx_nxt;
      Txbar   <= ~tx_nxt;
      Ready   <= ready_nxt;
      Busy    <= busy_nxt;
      Done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx. Four instances share Rst and Data_in; Valid
// is steered to the instance selected by sel:
//   0: CLKS_PER_BIT=4, even parity   1: CLKS_PER_BIT=4, odd parity
//   2: CLKS_PER_BIT=4, no parity     3: CLKS_PER_BIT=1, even parity
// A queue holds the expected line value for every cycle of each accepted
// frame; an empty queue means the line should be idle.

module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid;
  logic [7:0] data_in;
  logic [1:0] sel;
  logic [3:0] vld;
  logic [3:0] tx, txbar, ready, busy, done;
  logic [4:0] obs;    // {tx, txbar, ready, busy, done} of selected instance
  logic [4:0] exp_v;

  logic q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) vld[i] = valid && (sel == 2'(i));
    obs = {tx[sel], txbar[sel], ready[sel], busy[sel], done[sel]};
  end

  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .Clk(clk), .Rst(rst), .Data_in(data_in), .Valid(vld[0]), .Ready(ready[0]),
    .Tx(tx[0]), .Txbar(txbar[0]), .Busy(busy[0]), .Done(done[0]));
  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .Clk(clk), .Rst(rst), .Data_in(data_in), .Valid(vld[1]), .Ready(ready[1]),
    .Tx(tx[1]), .Txbar(txbar[1]), .Busy(busy[1]), .Done(done[1]));
  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .Clk(clk), .Rst(rst), .Data_in(data_in), .Valid(vld[2]), .Ready(ready[2]),
    .Tx(tx[2]), .Txbar(txbar[2]), .Busy(busy[2]), .Done(done[2]));
  serial_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_fast (
    .Clk(clk), .Rst(rst), .Data_in(data_in), .Valid(vld[3]), .Ready(ready[3]),
    .Tx(tx[3]), .Txbar(txbar[3]), .Busy(busy[3]), .Done(done[3]));

  task automatic push_frame(input logic [7:0] d);
    int   cpb;
    bit   pe;
    logic p;
    cpb = (sel == 2'd3) ? 1 : 4;
    pe  = (sel != 2'd2);
    p   = (^d) ^ (sel == 2'd1);
    for (int k = 0; k < cpb; k++) q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < cpb; k++) q.push_back(d[i]);
    if (pe)
      for (int k = 0; k < cpb; k++) q.push_back(p);
    for (int k = 0; k < cpb; k++) q.push_back(1'b1);
  endtask

  // One clock: update the reference at the edge, then settle and form exp_v.
  task automatic tick();
    @(posedge clk);
    if (rst) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (valid) push_frame(data_in);
    cyc++;
    #1;
    if (q.size() == 0) exp_v = 5'b10100;
    else exp_v = {q[0], ~q[0], 1'b0, 1'b1, (q.size() == 1)};
  endtask

  task automatic test_reset();
    sel = 2'd0; rst = 1'b1; valid = 1'b1; data_in = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs !== 5'b10100) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %b want %b", cyc, obs, 5'b10100);
      end
    end
    rst = 1'b0; valid = 1'b0;
    tick();
    vectors++;
    if (obs !== exp_v || obs !== 5'b10100) begin
      miscompares++;
      $display("FAIL reset_release cyc %0d: got %b want %b", cyc, obs, exp_v);
    end
  endtask

  task automatic test_single_even();
    logic [10:0] slots;
    slots = {1'b1, 1'b0, 8'hA5, 1'b0};
    sel = 2'd0; data_in = 8'hA5; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 46; i++) begin
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL single_even cyc %0d: got %b want %b", i, obs, exp_v);
      end
      if (i <= 44) begin
        vectors++;
        if (obs[4] !== slots[(i-1)/4]) begin
          miscompares++;
          $display("FAIL single_even_bit cyc %0d: tx %b want %b", i, obs[4], slots[(i-1)/4]);
        end
      end
      if (i == 44 || i == 45) begin
        vectors++;
        if (obs[2:0] !== ((i == 44) ? 3'b011 : 3'b100)) begin
          miscompares++;
          $display("FAIL single_even_end cyc %0d: rdy/busy/done %b", i, obs[2:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_odd_parity();
    sel = 2'd1; data_in = 8'h00; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 46; i++) begin
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL odd_parity cyc %0d: got %b want %b", i, obs, exp_v);
      end
      if (i >= 37 && i <= 40) begin
        vectors++;
        if (obs[4] !== 1'b1) begin
          miscompares++;
          $display("FAIL odd_parity_bit cyc %0d: tx %b want 1", i, obs[4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_no_parity();
    sel = 2'd2; data_in = 8'hFF; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 42; i++) begin
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL no_parity cyc %0d: got %b want %b", i, obs, exp_v);
      end
      if (i == 40 || i == 41) begin
        vectors++;
        if (obs[2:0] !== ((i == 40) ? 3'b011 : 3'b100)) begin
          miscompares++;
          $display("FAIL no_parity_end cyc %0d: rdy/busy/done %b", i, obs[2:0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    sel = 2'd0; data_in = 8'h3C; valid = 1'b1;
    tick();
    data_in = 8'hC3;
    for (int i = 1; i <= 91; i++) begin
      if (i == 46) valid = 1'b0;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, exp_v);
      end
      if (i == 45 || i == 46) begin
        vectors++;
        if (obs[4] !== (i == 45)) begin
          miscompares++;
          $display("FAIL back_to_back_gap cyc %0d: tx %b", i, obs[4]);
        end
      end
      tick();
    end
  endtask

  task automatic test_ignore_midframe();
    sel = 2'd0; data_in = 8'h96; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 46; i++) begin
      if (i == 10) begin valid = 1'b1; data_in = 8'h69; end
      if (i == 11) valid = 1'b0;
      if (i == 20) data_in = 8'hFF;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL ignore_midframe cyc %0d: got %b want %b", i, obs, exp_v);
      end
      if (i >= 10 && i <= 12) begin
        vectors++;
        if (obs[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL ignore_ready cyc %0d: ready %b want 0", i, obs[2]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    sel = 2'd0; data_in = 8'h5A; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rst_mid_pre cyc %0d: got %b want %b", i, obs, exp_v);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (obs !== 5'b10100 || obs !== exp_v) begin
      miscompares++;
      $display("FAIL rst_mid_idle: got %b want %b", obs, 5'b10100);
    end
    data_in = 8'h81; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 1; i <= 46; i++) begin
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL rst_mid_post cyc %0d: got %b want %b", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_cpb1();
    sel = 2'd3; data_in = 8'h6B; valid = 1'b1;
    tick();
    data_in = 8'h94;
    for (int i = 1; i <= 25; i++) begin
      if (i == 13) valid = 1'b0;
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL cpb1 cyc %0d: got %b want %b", i, obs, exp_v);
      end
      if (i == 11 || i == 13) begin
        vectors++;
        if (obs[4] !== (i == 11) || obs[0] !== (i == 11)) begin
          miscompares++;
          $display("FAIL cpb1_edge cyc %0d: tx %b done %b", i, obs[4], obs[0]);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; data_in = 8'h00; sel = 2'd0;
    test_reset();
    test_single_even();
    test_odd_parity();
    test_no_parity();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_cpb1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
